// File: rtl/wb_trace_fifo.sv
// Write-back trace capture: records architectural register writes with a cycle stamp
// into a first-word-fall-through FIFO; events arriving while full are dropped and counted.
module wb_trace_fifo #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  input  logic                     enable,
  input  logic                     clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_data,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + 32 + STAMP_W;

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;
  logic [STAMP_W-1:0] stamp;
  logic [7:0]         ovf;
  logic               cap;
  logic               pop;
  logic               push;
  logic               drop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  assign count     = cnt;
  assign overflow_cnt = ovf;

  assign cap  = wb_valid && enable && (wb_reg != 5'd0);
  assign pop  = out_valid && out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign {out_reg, out_data, out_stamp} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop && ovf != 8'hFF) ovf <= ovf + 8'd1;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (rst && push && !clr) mem[wr_ptr] <= {wb_reg, wb_data, stamp};
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized bench for wb_trace_fifo: a queue-based model of the capture/drop/drain
// rules is compared against the DUT every cycle, plus directed literal checks.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 0;
  logic        rst = 0;
  logic        wb_valid = 0;
  logic [4:0]  wb_reg = 0;
  logic [31:0] wb_data = 0;
  logic        enable = 0;
  logic        clr = 0;
  logic        out_ready = 0;
  logic        out_valid;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [7:0]  overflow_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(16)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .enable(enable), .clr(clr), .out_ready(out_ready), .out_valid(out_valid),
    .out_reg(out_reg), .out_data(out_data), .out_stamp(out_stamp), .count(count),
    .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] s;
  } entry_t;

  entry_t      mq[$];
  logic [15:0] mcycle = 0;
  int          movf = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: FIFO as a queue, rules applied at each rising edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mcycle = 0;
      movf = 0;
    end else begin
      bit c, p, was_full;
      entry_t e;
      c = wb_valid && enable && (wb_reg != 0);
      p = (mq.size() != 0) && out_ready;
      was_full = (mq.size() == DEPTH);
      if (clr) begin
        mq.delete();
        movf = 0;
      end else begin
        if (p) void'(mq.pop_front());
        if (c) begin
          if (!was_full || p) begin
            e.r = wb_reg; e.d = wb_data; e.s = mcycle;
            mq.push_back(e);
          end else if (movf < 255) begin
            movf++;
          end
        end
      end
      mcycle = mcycle + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("overflow_cnt", overflow_cnt, movf);
      if (mq.size() != 0) begin
        chk("out_reg", out_reg, mq[0].r);
        chk("out_data", out_data, mq[0].d);
        chk("out_stamp", out_stamp, mq[0].s);
      end
    end
  end

  task automatic idle();
    wb_valid = 0; clr = 0; out_ready = 0; enable = 1;
  endtask

  logic [31:0] drained[$];

  initial begin
    int thr;
    bit  hit;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow_cnt, 0);
    rst = 1;
    enable = 1;

    // basic capture in cycle 4 after release
    repeat (4) @(negedge clk);
    wb_valid = 1; wb_reg = 2; wb_data = 32'h5;
    @(negedge clk);
    wb_valid = 0;
    chk("cap_valid", out_valid, 1);
    chk("cap_reg", out_reg, 2);
    chk("cap_data", out_data, 5);
    chk("cap_stamp", out_stamp, 4);
    chk("cap_count", count, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("drain1_empty", empty, 1);

    // $0 filter and enable gating
    wb_valid = 1; wb_reg = 0; wb_data = 32'h77;
    @(negedge clk);
    wb_reg = 3; enable = 0;
    @(negedge clk);
    idle();
    chk("filter_count", count, 0);
    chk("filter_ovf", overflow_cnt, 0);

    // fill and overflow
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1; wb_reg = 5'(i % 31 + 1); wb_data = i;
      @(negedge clk);
      if (i == 15) chk("fill_full", full, 1);
    end
    idle();
    chk("fill_ovf", overflow_cnt, 4);

    // full with simultaneous push and pop
    wb_valid = 1; wb_reg = 7; wb_data = 32'hAA; out_ready = 1;
    @(negedge clk);
    idle();
    chk("pp_count", count, 16);
    chk("pp_ovf", overflow_cnt, 4);
    out_ready = 1;
    hit = 0;
    for (int n = 0; n < 40; n++) begin
      if (!out_valid) begin hit = 1; break; end
      drained.push_back(out_data);
      @(negedge clk);
    end
    out_ready = 0;
    chk("drain_done", hit, 1);
    chk("drain_len", drained.size(), 16);
    if (drained.size() == 16) begin
      chk("drain_first", drained[0], 1);
      chk("drain_15", drained[14], 15);
      chk("drain_last", drained[15], 32'hAA);
    end
    chk("drain_empty", empty, 1);

    // randomized traffic with varying consumer rate
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) thr = $urandom_range(0, 4);
      wb_valid  = ($urandom_range(0, 3) != 0);
      wb_reg    = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) < thr);
      clr       = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    idle();
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("flush_count", count, 0);

    // stamp wrap
    hit = 0;
    for (int n = 0; n < 70000; n++) begin
      if (mcycle == 16'hFFFF) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("wrap_reached", hit, 1);
    wb_valid = 1; wb_reg = 5; wb_data = 32'h111;
    @(negedge clk);
    wb_reg = 6; wb_data = 32'h222;
    @(negedge clk);
    idle();
    chk("wrap_count", count, 2);
    chk("wrap_stamp_ffff", out_stamp, 16'hFFFF);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("wrap_stamp_0", out_stamp, 0);
    chk("wrap_data", out_data, 32'h222);

    // overflow again, then clr together with cap and pop
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1; wb_reg = 9; wb_data = 32'h300 + i;
      @(negedge clk);
    end
    chk("ovf2", overflow_cnt, 5);
    wb_valid = 1; wb_reg = 9; wb_data = 32'hBEEF; out_ready = 1; clr = 1;
    @(negedge clk);
    idle();
    chk("clr_count", count, 0);
    chk("clr_ovf", overflow_cnt, 0);
    chk("clr_valid", out_valid, 0);

    // async reset mid-drain
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1; wb_reg = 10; wb_data = 32'h400 + i; out_ready = i[0];
      @(negedge clk);
    end
    idle();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    @(negedge clk);
    out_ready = 1;
    #2 rst = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    @(negedge clk);
    out_ready = 0;
    rst = 1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
